// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the instruction loader.
// The loader takes the master modport; the byte source and RAM take the slave side.
interface inst_loader_if;
    // A byte moves on a rising edge only when byte_valid && byte_ready are both high.
    // The source holds byte_data stable while byte_valid is high and not yet accepted.
    // we is a one-cycle write strobe; waddr/wdata are meaningful only while we is high.
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, we, waddr, wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata
    );
endinterface

// File: rtl/inst_loader.sv
// Packs a byte stream big-endian into 32-bit words and writes them into instruction RAM.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int DEPTH = 256,
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    inst_loader_if.master    bus,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             err,
    output logic             chk_err,
    output logic [2:0]       dbg_state
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd3
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      shreg_q, shreg_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             xfer;
    logic             last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
    logic             chk_err_q, chk_err_d;
`endif

    assign bus.byte_ready = (state_q == S_LOAD)
`ifdef LOADER_CHECKSUM_EN
                          || (state_q == S_CHECK)
`endif
                          ;
    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign last_word = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
        chk_err_d = chk_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_err_d = 1'b0;
                    csum_d    = 8'h00;
`endif
                    if (load_len == '0) begin
                        state_d = S_DONE;
                    end else if (load_len > LEN_W'(DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = load_len;
                        idx_d   = '0;
                        cnt_d   = 2'd0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    shreg_d = {shreg_q[23:0], bus.byte_data};
                    cnt_d   = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ bus.byte_data;
`endif
                    // Register the write here so we/waddr/wdata are flops during WRITE.
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        wdata_d = {shreg_q[23:0], bus.byte_data};
                        waddr_d = {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (xfer) begin
                    if (bus.byte_data != csum_q) chk_err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= 2'd0;
            shreg_q <= 32'h0;
            we_q    <= 1'b0;
            waddr_q <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= 8'h00;
            chk_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
            chk_err_q <= chk_err_d;
`endif
        end
    end

    assign bus.we    = we_q;
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign cpu_hold  = busy;
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign dbg_state = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign chk_err   = chk_err_q;
`else
    assign chk_err   = 1'b0;
`endif
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected RAM writes go into a queue and a negedge monitor
// pops and compares them whenever we is high; control outputs are checked inline.
module tb_inst_loader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] load_len;
    logic       busy, cpu_hold, done, err, chk_err;
    logic [2:0] dbg_state;

    inst_loader_if bus();

    inst_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .bus       (bus),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .chk_err   (chk_err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  tb_csum;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected {waddr, wdata}.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_we: got waddr %h wdata %h expected no write", bus.waddr, bus.wdata);
            end else begin
                check("ram_write", {bus.waddr, bus.wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
        load_len = 9'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("byte_ready_timeout", 1'b0, 1'b1);
        tick();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        if (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap, input bit chk_we);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8], gap);
            tb_csum ^= w[i*8 +: 8];
            if (i == 0 && !gap && chk_we) check("we_after_4th_byte", bus.we, 1'b1);
        end
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum, 1'b0);
`endif
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("done_seen", done, 1'b1);
        check("busy_during_done", busy, 1'b1);
        tick();
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        check("cpu_hold_after_done", cpu_hold, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        load_len       = 9'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        tb_csum        = 8'h00;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_we", bus.we, 1'b0);
        check("rst_waddr", bus.waddr, 32'h0);
        check("rst_wdata", bus.wdata, 32'h0);
        check("rst_byte_ready", bus.byte_ready, 1'b0);
        check("rst_chk_err", chk_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // T1: two words, continuous stream.
        exp_q.push_back({32'h0, 32'h8C1F0000});
        exp_q.push_back({32'h4, 32'h001FF022});
        tb_csum = 8'h00;
        do_start(9'd2);
        check("t1_busy", busy, 1'b1);
        check("t1_cpu_hold", cpu_hold, 1'b1);
        send_word(32'h8C1F0000, 1'b0, 1'b1);
        send_word(32'h001FF022, 1'b0, 1'b1);
        finish_load();
        wait_done();

        // Bytes offered in IDLE must not be consumed.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        tick();
        check("idle_byte_ready", bus.byte_ready, 1'b0);
        tick();
        bus.byte_valid = 1'b0;

        // T2: same data with byte_valid toggling.
        exp_q.push_back({32'h0, 32'h8C1F0000});
        exp_q.push_back({32'h4, 32'h001FF022});
        tb_csum = 8'h00;
        do_start(9'd2);
        send_word(32'h8C1F0000, 1'b1, 1'b0);
        send_word(32'h001FF022, 1'b1, 1'b0);
        finish_load();
        wait_done();

        // T3: zero-length load and oversize length.
        do_start(9'd0);
        check("t3_len0_done", done, 1'b1);
        tick();
        check("t3_len0_done_clear", done, 1'b0);
        check("t3_len0_busy", busy, 1'b0);
        do_start(9'd257);
        check("t3_err_pulse", err, 1'b1);
        check("t3_err_busy", busy, 1'b0);
        tick();
        check("t3_err_clear", err, 1'b0);
        check("t3_err_busy_after", busy, 1'b0);

        // T4: reset in the middle of a word.
        do_start(9'd1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t4_busy", busy, 1'b0);
        check("t4_we", bus.we, 1'b0);
        check("t4_waddr", bus.waddr, 32'h0);
        check("t4_wdata", bus.wdata, 32'h0);
        check("t4_state", dbg_state, 3'd0);
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        tb_csum = 8'h00;
        do_start(9'd1);
        send_word(32'hDEADBEEF, 1'b0, 1'b1);
        finish_load();
        wait_done();

        // T5: full-depth load with a stray start mid-load.
        tb_csum = 8'h00;
        for (int i = 0; i < 256; i++) exp_q.push_back({32'(i) << 2, 32'hA5000000 | 32'(i * 3)});
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            send_word(32'hA5000000 | 32'(i * 3), 1'b0, 1'b0);
            if (i == 10) begin
                do_start(9'd3);
                check("t5_stray_start_busy", busy, 1'b1);
            end
        end
        finish_load();
        wait_done();
        check("t5_last_waddr", bus.waddr, 32'h3FC);
        check("t5_last_wdata", bus.wdata, 32'hA50002FD);
        check("chk_err_clean", chk_err, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // T6: checksum good then bad.
        exp_q.push_back({32'h0, 32'h2417AB00});
        tb_csum = 8'h00;
        do_start(9'd1);
        send_word(32'h2417AB00, 1'b0, 1'b1);
        send_byte(8'h98, 1'b0);
        wait_done();
        check("t6_chk_ok", chk_err, 1'b0);
        exp_q.push_back({32'h0, 32'h2417AB00});
        do_start(9'd1);
        send_word(32'h2417AB00, 1'b0, 1'b1);
        send_byte(8'h00, 1'b0);
        wait_done();
        check("t6_chk_bad", chk_err, 1'b1);
        tick();
        check("t6_chk_sticky", chk_err, 1'b1);
`endif

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
